rob_alloc: RTL

ROB_ALLOC -- requirements
Module: rob_alloc

---
 rtl/rob_alloc_if.sv | 29 ++
 rtl/rob_alloc.sv | 102 ++++++++++
 2 files changed

// File: rtl/rob_alloc_if.sv
// Allocation/commit handshake between decode, the ROB and rob_alloc.
interface rob_alloc_if #(
    parameter int ROB_IDX_BITS = 4
);
    logic                    clear;
    logic                    allocReq;
    logic                    allocGnt;
    logic [ROB_IDX_BITS-1:0] allocIdx;
    logic                    commitValid;
    logic [ROB_IDX_BITS-1:0] commitIdx;
    logic [ROB_IDX_BITS-1:0] headIdx;
    logic [ROB_IDX_BITS:0]   count;
    logic                    full;
    logic                    empty;
    logic                    stall;
    logic                    errOrder;

    // Decode/ROB side: issues requests, commits and flushes.
    modport master (
        output clear, allocReq, commitValid, commitIdx,
        input  allocGnt, allocIdx, headIdx, count, full, empty, stall, errOrder
    );

    // Allocator side.
    modport slave (
        input  clear, allocReq, commitValid, commitIdx,
        output allocGnt, allocIdx, headIdx, count, full, empty, stall, errOrder
    );
endinterface

// File: rtl/rob_alloc.sv
// Reorder-buffer slot allocator: circular tail/head pointers, in-flight
// bitmap, zero-latency grant, in-order commit checking and flush handling.
module rob_alloc #(
    parameter int ROB_SLOTS    = 16,
    parameter int ROB_IDX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    rob_alloc_if.slave   bus
);
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [ROB_IDX_BITS:0] SLOTS_CNT = (ROB_IDX_BITS+1)'(ROB_SLOTS);

    state_t                  state, state_nxt;
    logic [ROB_IDX_BITS-1:0] head, tail;
    logic [ROB_IDX_BITS:0]   count;
    logic [ROB_SLOTS-1:0]    inflight;
    logic                    err_order;
    logic                    gnt, commit_ok, commit_bad;
    logic                    full;

    // Full comes from the registered count only, so a commit in the same
    // cycle never frees a slot for a same-cycle allocation.
    assign full = (count == SLOTS_CNT);

    // Next state plus grant/commit qualification; clear and FLUSH mask both.
    always_comb begin
        state_nxt  = state;
        gnt        = 1'b0;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        case (state)
            RUN: begin
                if (bus.clear) begin
                    state_nxt = FLUSH;
                end else begin
                    gnt = bus.allocReq && !full && !rst;
                    if (bus.commitValid) begin
                        if (inflight[bus.commitIdx] && (bus.commitIdx == head))
                            commit_ok = 1'b1;
                        else
                            commit_bad = 1'b1;
                    end
                end
            end
            FLUSH:   state_nxt = bus.clear ? FLUSH : RUN;
            default: state_nxt = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Pointers, occupancy and in-flight bitmap; a grant never targets a live
    // slot because it is blocked while full, so the two bitmap writes cannot collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
        end else if (bus.clear) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
        end else begin
            if (gnt) begin
                tail           <= tail + 1'b1;
                inflight[tail] <= 1'b1;
            end
            if (commit_ok) begin
                head                    <= head + 1'b1;
                inflight[bus.commitIdx] <= 1'b0;
            end
            case ({gnt, commit_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky protocol error; only reset clears it, a flush keeps it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err_order <= 1'b0;
        else if (commit_bad) err_order <= 1'b1;
    end

    assign bus.allocGnt = gnt;
    assign bus.allocIdx = tail;
    assign bus.headIdx  = head;
    assign bus.count    = count;
    assign bus.full     = full;
    assign bus.empty    = (count == '0);
    assign bus.stall    = bus.allocReq && !gnt;
    assign bus.errOrder = err_order;
endmodule
